// File: rtl/fc_layer_sequencer.sv
// -----------------------------------------------------------------------------
// fc_layer_sequencer
//
// Address and control sequencer for one fully-connected layer. For each of the
// N_OUT neurons it clears the accumulator, streams N_IN operand pairs into the
// MAC (activation index + weight ROM address), waits MAC_LAT cycles for the
// MAC pipeline to drain, then flags the accumulator result for write-back.
// A single done pulse closes the layer pass.
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous reset, active high
//   start        request a full layer pass (only looked at in IDLE)
//   stall        operand data not available; freezes the MAC phase only
//   busy         high whenever the sequencer is not idle
//   acc_clr      clear the accumulator
//   mac_en       MAC consumes the operands addressed this cycle
//   in_idx       activation read address
//   out_idx      neuron currently being computed / written
//   weight_addr  weight ROM address (out_idx*N_IN + in_idx while mac_en)
//   wb_valid     accumulator result valid for neuron out_idx
//   done         one-cycle pulse at the end of the layer
//
// State table
//   state  | meaning
//   IDLE   | waiting for start; counters hold their last values
//   CLEAR  | one cycle, accumulator cleared
//   MAC    | one operand pair per unstalled cycle, N_IN pairs per neuron
//   DRAIN  | MAC_LAT cycles for the MAC pipeline to empty (stall ignored)
//   WRITE  | one cycle, accumulator result valid for out_idx
//   DONE   | one cycle end-of-layer pulse, then back to IDLE
// -----------------------------------------------------------------------------
module fc_layer_sequencer #(
   parameter int N_IN        = 784,
   parameter int N_IN_BITS   = 10,
   parameter int N_OUT       = 10,
   parameter int N_OUT_BITS  = 4,
   parameter int W_ADDR_BITS = 13,
   parameter int MAC_LAT     = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   stall,
   output logic                   busy,
   output logic                   acc_clr,
   output logic                   mac_en,
   output logic [N_IN_BITS-1:0]   in_idx,
   output logic [N_OUT_BITS-1:0]  out_idx,
   output logic [W_ADDR_BITS-1:0] weight_addr,
   output logic                   wb_valid,
   output logic                   done
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_MAC   = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam logic [N_IN_BITS-1:0]   IN_LAST    = N_IN_BITS'(N_IN - 1);
   localparam logic [N_IN_BITS-1:0]   IN_ONE     = N_IN_BITS'(1);
   localparam logic [N_OUT_BITS-1:0]  OUT_LAST   = N_OUT_BITS'(N_OUT - 1);
   localparam logic [N_OUT_BITS-1:0]  OUT_ONE    = N_OUT_BITS'(1);
   localparam logic [W_ADDR_BITS-1:0] ADDR_ONE   = W_ADDR_BITS'(1);
   // Drain counter is a down-counter loaded with MAC_LAT-1; DRAIN exits on
   // terminal count 0, giving exactly MAC_LAT cycles (MAC_LAT <= 15).
   localparam logic [3:0]             DRAIN_LOAD = 4'(MAC_LAT - 1);

   logic [2:0] state;
   logic [2:0] state_nxt;
   logic [3:0] drain_cnt;
   logic       in_last;
   logic       drain_tc;

   assign in_last  = (in_idx == IN_LAST);
   assign drain_tc = (drain_cnt == 4'd0);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_CLEAR;
         S_CLEAR: state_nxt = S_MAC;
         S_MAC:   if (!stall && in_last) state_nxt = S_DRAIN;
         S_DRAIN: if (drain_tc) state_nxt = S_WRITE;
         S_WRITE: state_nxt = (out_idx == OUT_LAST) ? S_DONE : S_CLEAR;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // weight_addr is never reset between neurons: after the last MAC of neuron
   // k it already sits at (k+1)*N_IN, so a running increment replaces the
   // out_idx*N_IN product.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         in_idx      <= '0;
         out_idx     <= '0;
         weight_addr <= '0;
         drain_cnt   <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (start) begin
                  in_idx      <= '0;
                  out_idx     <= '0;
                  weight_addr <= '0;
               end
            end
            S_MAC: begin
               if (!stall) begin
                  weight_addr <= weight_addr + ADDR_ONE;
                  if (in_last) begin
                     in_idx    <= '0;
                     drain_cnt <= DRAIN_LOAD;
                  end else begin
                     in_idx <= in_idx + IN_ONE;
                  end
               end
            end
            S_DRAIN: begin
               if (!drain_tc) drain_cnt <= drain_cnt - 4'd1;
            end
            S_WRITE: begin
               if (out_idx != OUT_LAST) out_idx <= out_idx + OUT_ONE;
            end
            default: ;
         endcase
      end
   end

   // Strobes decode straight from the state register (plus stall for mac_en),
   // so they are mutually exclusive by construction and all fall to 0 the
   // moment rst forces IDLE.
   assign busy     = (state != S_IDLE);
   assign acc_clr  = (state == S_CLEAR);
   assign mac_en   = (state == S_MAC) && !stall;
   assign wb_valid = (state == S_WRITE);
   assign done     = (state == S_DONE);

endmodule

// File: tb/tb_fc_layer_sequencer.sv
module tb_fc_layer_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       stall;
   logic       busy;
   logic       acc_clr;
   logic       mac_en;
   logic [2:0] in_idx;
   logic [1:0] out_idx;
   logic [3:0] weight_addr;
   logic       wb_valid;
   logic       done;

   int n_checks = 0;
   int n_fail   = 0;

   // {busy, acc_clr, mac_en, wb_valid, done, in_idx, out_idx, weight_addr}
   logic [13:0] obs_vec;
   assign obs_vec = {busy, acc_clr, mac_en, wb_valid, done, in_idx, out_idx, weight_addr};

   localparam logic [13:0] ZERO_VEC  = 14'd0;
   localparam logic [13:0] FINAL_IDLE = {5'b00000, 3'd0, 2'd2, 4'd12};

   fc_layer_sequencer #(
      .N_IN(4), .N_IN_BITS(3), .N_OUT(3), .N_OUT_BITS(2),
      .W_ADDR_BITS(4), .MAC_LAT(2)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .stall(stall),
      .busy(busy), .acc_clr(acc_clr), .mac_en(mac_en),
      .in_idx(in_idx), .out_idx(out_idx), .weight_addr(weight_addr),
      .wb_valid(wb_valid), .done(done)
   );

   always #5 clk = ~clk;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [13:0] o, input logic [13:0] e);
      n_checks++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b (busy,clr,mac,wb,done,in,out,addr)", tag, o, e);
      end
   endtask

   // Unstalled timeline, c = cycles after the start cycle: each neuron takes
   // 8 cycles (CLEAR, 4x MAC, 2x DRAIN, WRITE), DONE in 25, IDLE from 26.
   function automatic logic [13:0] base_exp(input int c);
      int n, p;
      if (c >= 26) return FINAL_IDLE;
      if (c == 25) return {5'b10001, 3'd0, 2'd2, 4'd12};
      n = (c - 1) / 8;
      p = (c - 1) % 8;
      if (p == 0)      return {5'b11000, 3'd0, 2'(n), 4'(n * 4)};
      else if (p <= 4) return {5'b10100, 3'(p - 1), 2'(n), 4'(n * 4 + p - 1)};
      else if (p <= 6) return {5'b10000, 3'd0, 2'(n), 4'(n * 4 + 4)};
      else             return {5'b10010, 3'd0, 2'(n), 4'(n * 4 + 4)};
   endfunction

   function automatic logic [13:0] exp_vec(input int mode, input int c);
      if (mode == 3) begin
         if (c >= 12 && c <= 14) return {5'b10000, 3'd2, 2'd1, 4'd6};
         if (c >= 15) return base_exp(c - 3);
         return base_exp(c);
      end
      if (mode == 1 && c == 27) return {5'b11000, 3'd0, 2'd0, 4'd0};
      return base_exp(c);
   endfunction

   // mode 0: plain pass; 1: start held high; 2: stall in CLEAR/DRAIN/WRITE;
   // 3: stall 3 cycles at in_idx=2 of neuron 1. Entered just after an edge.
   task automatic run_pass(input int mode, input string name, input logic [13:0] exp0,
                           input int last);
      int p;
      start = 1'b1;
      stall = 1'b0;
      #1;
      chk($sformatf("%s_c0", name), obs_vec, exp0);
      for (int c = 1; c <= last; c++) begin
         next_cycle();
         start = (mode == 1);
         stall = 1'b0;
         if (mode == 2) begin
            p = (c - 1) % 8;
            stall = (c <= 24) && (p == 0 || p >= 5);
         end
         if (mode == 3) stall = (c >= 12 && c <= 14);
         #1;
         chk($sformatf("%s_c%0d", name, c), obs_vec, exp_vec(mode, c));
      end
      start = 1'b0;
      stall = 1'b0;
   endtask

   initial begin
      rst   = 1'b0;
      start = 1'b0;
      stall = 1'b0;
      #1 rst = 1'b1;
      #1 chk("reset_async", obs_vec, ZERO_VEC);
      next_cycle();
      chk("reset_held", obs_vec, ZERO_VEC);
      rst = 1'b0;

      // stall in IDLE without start must not wake anything up
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         stall = 1'b1;
         #1 chk($sformatf("idle_stall_%0d", i), obs_vec, ZERO_VEC);
      end
      stall = 1'b0;
      next_cycle();

      run_pass(0, "base",       ZERO_VEC,   26);
      next_cycle();
      run_pass(2, "stall_ctl",  FINAL_IDLE, 26);
      next_cycle();
      run_pass(3, "stall_mac",  FINAL_IDLE, 29);
      next_cycle();
      run_pass(1, "start_held", FINAL_IDLE, 27);

      // clean up the second pass the held start launched
      next_cycle();
      rst = 1'b1;
      #1 chk("reset_in_mac", obs_vec, ZERO_VEC);
      next_cycle();
      rst = 1'b0;
      next_cycle();

      // abort mid-pass: reset between edges in cycle 12
      run_pass(0, "abort", ZERO_VEC, 12);
      #2 rst = 1'b1;
      #1 chk("abort_async", obs_vec, ZERO_VEC);
      for (int i = 0; i < 16; i++) begin
         next_cycle();
         if (i == 2) rst = 1'b0;
         #1 chk($sformatf("abort_quiet_%0d", i), obs_vec, ZERO_VEC);
      end
      next_cycle();
      run_pass(0, "after_rst", ZERO_VEC, 26);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
